// File: rtl/gray_arb_pkg.sv
// Shared types, defaults and the Gray-to-binary helper for gray_conv_arbiter.
package gray_arb_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_N_REQ = 4;
    localparam int MAX_WIDTH     = 16;

    typedef enum logic {
        ST_IDLE,
        ST_FULL
    } state_t;

    // Zero-extended inputs leave a zero prefix, so one maximum-width XOR chain serves every WIDTH.
    function automatic logic [MAX_WIDTH-1:0] g2b(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b = '0;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int k = MAX_WIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot choice of the first valid requester at or after ptr.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick
);

    logic found;
    int   idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && valid[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared Gray-to-binary converter with a registered valid/ready output.
// Optional saturating grant counter enabled by defining GRAY_ARB_CNT_EN.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_gray,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_binary,
    output logic [IDW-1:0]         out_id,
    input  logic                   out_ready
`ifdef GRAY_ARB_CNT_EN
    ,
    output logic [7:0]             grant_count
`endif
);

    state_t                 state, state_next;
    logic [IDW-1:0]         ptr;
    logic [N_REQ-1:0]       pick;
    logic                   accept_ok;
    logic                   accept;
    logic [IDW-1:0]         grant_idx;
    logic [IDW-1:0]         ptr_next;
    logic [WIDTH-1:0]       sel_gray;
    logic [MAX_WIDTH-1:0]   conv;

    rr_pick #(
        .N  (N_REQ),
        .PW (IDW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .pick  (pick)
    );

    // A new word may load when the register is empty or is being drained this same cycle.
    always_comb begin
        accept_ok = (state == ST_IDLE) || ((state == ST_FULL) && out_ready);
        req_ready = (accept_ok && !rst) ? pick : '0;
        accept    = |(req_valid & req_ready);
        grant_idx = '0;
        ptr_next  = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                grant_idx = IDW'(i);
                ptr_next  = IDW'((i + 1) % N_REQ);
            end
        end
        sel_gray = req_gray[grant_idx*WIDTH +: WIDTH];
        conv     = g2b(MAX_WIDTH'(sel_gray));
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_FULL;
            ST_FULL: begin
                if (accept)         state_next = ST_FULL;
                else if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            out_binary <= '0;
            out_id     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                out_binary <= conv[WIDTH-1:0];
                out_id     <= grant_idx;
                ptr        <= ptr_next;
            end
        end
    end

    assign out_valid = (state == ST_FULL);

`ifdef GRAY_ARB_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count <= '0;
        end else if (accept && (grant_count != 8'hFF)) begin
            grant_count <= grant_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter (4 requesters, 4-bit words).
module tb_gray_conv_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_gray;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_binary;
    logic [1:0]  out_id;
    logic        out_ready;
`ifdef GRAY_ARB_CNT_EN
    logic [7:0]  grant_count;
`endif

    int vectors;
    int miscompares;

    gray_conv_arbiter #(
        .N_REQ (4),
        .WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_binary (out_binary),
        .out_id     (out_id),
        .out_ready  (out_ready)
`ifdef GRAY_ARB_CNT_EN
        ,
        .grant_count (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_gray  = 16'h1234;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0000) begin
            $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready);
            miscompares++;
        end
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_binary !== 4'h0 || out_id !== 2'd0) begin
            $display("[TB] FAIL reset_outputs: got v=%b b=%h id=%0d expected v=0 b=0 id=0",
                     out_valid, out_binary, out_id);
            miscompares++;
        end
        req_valid = '0;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_gray  = 16'h0000;
        req_gray[8 +: 4] = 4'b1101;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            $display("[TB] FAIL single_ready: got %b expected 0100", req_ready);
            miscompares++;
        end
        tick();
        req_valid = '0;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_binary !== 4'b1001 || out_id !== 2'd2) begin
            $display("[TB] FAIL single_out: got v=%b b=%b id=%0d expected v=1 b=1001 id=2",
                     out_valid, out_binary, out_id);
            miscompares++;
        end
        vectors++;
        if (req_ready !== 4'b0000) begin
            $display("[TB] FAIL single_ready_drop: got %b expected 0000", req_ready);
            miscompares++;
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("[TB] FAIL single_drain: got out_valid=%b expected 0", out_valid);
            miscompares++;
        end
    endtask

    // ptr is 3 on entry, so requester 3 wins over requester 0.
    task automatic test_backpressure();
        out_ready = 1'b0;
        req_valid = 4'b1001;
        req_gray  = 16'h0000;
        req_gray[0 +: 4]  = 4'b0110;
        req_gray[12 +: 4] = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin
            $display("[TB] FAIL bp_first_ready: got %b expected 1000", req_ready);
            miscompares++;
        end
        tick();
        req_valid = 4'b0001;
        #1;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_binary !== 4'b1010 || out_id !== 2'd3 ||
                req_ready !== 4'b0000) begin
                $display("[TB] FAIL bp_hold%0d: got v=%b b=%b id=%0d rdy=%b expected v=1 b=1010 id=3 rdy=0000",
                         c, out_valid, out_binary, out_id, req_ready);
                miscompares++;
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            $display("[TB] FAIL bp_release_ready: got %b expected 0001", req_ready);
            miscompares++;
        end
        tick();
        req_valid = '0;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_binary !== 4'b0100 || out_id !== 2'd0) begin
            $display("[TB] FAIL bp_second_word: got v=%b b=%b id=%0d expected v=1 b=0100 id=0",
                     out_valid, out_binary, out_id);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [5];
        logic [3:0] exp_bin [4];
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_bin = '{4'b0100, 4'b1111, 4'b0001, 4'b1010};
        do_reset();
        req_gray = {4'b1111, 4'b0001, 4'b1000, 4'b0110};
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_id !== exp_id[c] || out_binary !== exp_bin[c % 4]) begin
                $display("[TB] FAIL rr_grant%0d: got v=%b id=%0d b=%b expected v=1 id=%0d b=%b",
                         c, out_valid, out_id, out_binary, exp_id[c], exp_bin[c % 4]);
                miscompares++;
            end
        end
        req_valid = '0;
        tick();
    endtask

    // Granting requester 1 alone leaves ptr at 2 before the sparse pattern starts.
    task automatic test_sparse();
        logic [1:0] exp_id [3];
        logic [3:0] exp_bin [3];
        exp_id  = '{2'd3, 2'd1, 2'd3};
        exp_bin = '{4'b1000, 4'b0010, 4'b1000};
        do_reset();
        req_gray = {4'b1100, 4'b0000, 4'b0011, 4'b0000};
        out_ready = 1'b1;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_id !== exp_id[c] || out_binary !== exp_bin[c]) begin
                $display("[TB] FAIL sparse_grant%0d: got v=%b id=%0d b=%b expected v=1 id=%0d b=%b",
                         c, out_valid, out_id, out_binary, exp_id[c], exp_bin[c]);
                miscompares++;
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b0;
        req_gray  = 16'h0000;
        req_gray[4 +: 4] = 4'b0110;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0001;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 2'd1) begin
            $display("[TB] FAIL mid_loaded: got v=%b id=%0d expected v=1 id=1", out_valid, out_id);
            miscompares++;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0000) begin
            $display("[TB] FAIL mid_rst_ready: got %b expected 0000", req_ready);
            miscompares++;
        end
        tick();
        rst = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("[TB] FAIL mid_rst_valid: got %b expected 0", out_valid);
            miscompares++;
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("[TB] FAIL mid_no_emit: got %b expected 0", out_valid);
            miscompares++;
        end
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            $display("[TB] FAIL mid_ptr_zero: got %b expected 0001", req_ready);
            miscompares++;
        end
        req_valid = '0;
        tick();
    endtask

`ifdef GRAY_ARB_CNT_EN
    task automatic test_counter();
        do_reset();
        vectors++;
        if (grant_count !== 8'd0) begin
            $display("[TB] FAIL cnt_reset: got %0d expected 0", grant_count);
            miscompares++;
        end
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 300; c++) tick();
        req_valid = '0;
        tick();
        vectors++;
        if (grant_count !== 8'd255) begin
            $display("[TB] FAIL cnt_saturate: got %0d expected 255", grant_count);
            miscompares++;
        end
        do_reset();
        vectors++;
        if (grant_count !== 8'd0) begin
            $display("[TB] FAIL cnt_clear: got %0d expected 0", grant_count);
            miscompares++;
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req_valid   = '0;
        req_gray    = '0;
        out_ready   = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_sparse();
        test_mid_reset();
`ifdef GRAY_ARB_CNT_EN
        test_counter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
